// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable PAT_LEN-bit pattern, a per-bit
// valid qualifier, selectable overlap, a registered match pulse and a saturating counter.
module seq_detector_param #(
    parameter int                 PAT_LEN   = 4,
    parameter int                 CNT_W     = 8,
    parameter logic [PAT_LEN-1:0] RESET_PAT = 4'b1010
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               load_pat,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               overlap,
    output logic               z,
    output logic [CNT_W-1:0]   match_count
);

    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_LEN);
    localparam logic [FW-1:0] FILL_MIN  = FW'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] pat_reg;
    logic [PAT_LEN-1:0] hist;
    logic [FW-1:0]      fill;
    logic [PAT_LEN-1:0] cand;
    logic               hit;

    // fill gates the compare so a zero-filled history can never alias a pattern
    always_comb begin
        cand = {hist[PAT_LEN-2:0], x};
        hit  = (fill >= FILL_MIN) && (cand == pat_reg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_reg     <= RESET_PAT;
            hist        <= '0;
            fill        <= '0;
            z           <= 1'b0;
            match_count <= '0;
        end else if (load_pat) begin
            pat_reg     <= pattern;
            hist        <= '0;
            fill        <= '0;
            z           <= 1'b0;
            match_count <= '0;
        end else if (x_valid) begin
            hist <= cand;
            z    <= hit;
            if (hit) begin
                // non-overlap restarts the fill so matched bits are not reused
                fill <= overlap ? FILL_FULL : '0;
                if (match_count != '1)
                    match_count <= match_count + 1'b1;
            end else if (fill != FILL_FULL) begin
                fill <= fill + 1'b1;
            end
        end else begin
            z <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed bench for seq_detector_param; expected values come from a
// queue-based model of the accepted bit stream.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       load_pat = 1'b0;
    logic [3:0] pattern = 4'b0000;
    logic       overlap = 1'b0;
    logic       z, z2;
    logic [7:0] match_count;
    logic [1:0] match_count2;

    int checks = 0;
    int failures = 0;

    // model: last accepted bits since the last clear, current pattern, counters
    bit       mq[$];
    bit [3:0] mpat;
    bit       mz;
    int       mcnt, mcnt2;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_LEN(4), .CNT_W(8), .RESET_PAT(4'b1010)) dut (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .load_pat(load_pat),
        .pattern(pattern), .overlap(overlap), .z(z), .match_count(match_count)
    );

    seq_detector_param #(.PAT_LEN(4), .CNT_W(2), .RESET_PAT(4'b1010)) dut_sat (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .load_pat(load_pat),
        .pattern(pattern), .overlap(overlap), .z(z2), .match_count(match_count2)
    );

    task automatic do_reset(input int n);
        reset = 1'b1; x_valid = 1'b0; load_pat = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete(); mpat = 4'b1010; mz = 1'b0; mcnt = 0; mcnt2 = 0;
    endtask

    // one clock of stimulus; the model advances by the same rules
    task automatic drive(input bit bx, input bit bv, input bit bo, input bit bl = 1'b0,
                         input bit [3:0] bp = 4'b0000);
        bit [3:0] last;
        x = bx; x_valid = bv; overlap = bo; load_pat = bl; pattern = bp;
        if (bl) begin
            mpat = bp; mq.delete(); mz = 1'b0; mcnt = 0; mcnt2 = 0;
        end else if (bv) begin
            mq.push_back(bx);
            if (mq.size() > 4) void'(mq.pop_front());
            mz = 1'b0;
            if (mq.size() == 4) begin
                last = {mq[0], mq[1], mq[2], mq[3]};
                mz = (last == mpat);
            end
            if (mz) begin
                if (mcnt < 255) mcnt++;
                if (mcnt2 < 3) mcnt2++;
                if (!bo) mq.delete();
            end
        end else begin
            mz = 1'b0;
        end
        @(posedge clk);
        #1;
        load_pat = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if (z !== 1'b0) begin failures++; $display("FAIL reset_z got=%b exp=0", z); end
        checks++;
        if (match_count !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", match_count); end
        checks++;
        if (match_count2 !== 2'd0) begin failures++; $display("FAIL reset_cnt_sat got=%0d exp=0", match_count2); end
    endtask

    task automatic run_stream(input string name, input bit ov, input int p0, input int p1, input int exp_cnt);
        bit s[12] = '{0,0,1,0,1,0,1,0,0,1,1,0};
        bit e;
        do_reset(2);
        for (int i = 0; i < 12; i++) begin
            drive(s[i], 1'b1, ov);
            e = (i == p0) || (i == p1);
            checks++;
            if (z !== e || z !== mz) begin
                failures++; $display("FAIL %s_z bit=%0d got=%b exp=%b", name, i, z, e);
            end
        end
        checks++;
        if (match_count !== 8'(exp_cnt) || mcnt != exp_cnt) begin
            failures++; $display("FAIL %s_cnt got=%0d exp=%0d", name, match_count, exp_cnt);
        end
    endtask

    task automatic test_nonoverlap(); run_stream("nonov", 1'b0, 5, 5, 1); endtask
    task automatic test_overlap();    run_stream("ov", 1'b1, 5, 7, 2);    endtask

    task automatic test_load();
        bit e;
        do_reset(1);
        repeat (3) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'b1111);
        checks++;
        if (z !== 1'b0 || match_count !== 8'd0) begin
            failures++; $display("FAIL load_clear z=%b cnt=%0d exp z=0 cnt=0", z, match_count);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            e = (i == 3) || (i == 7);
            checks++;
            if (z !== e || z !== mz) begin failures++; $display("FAIL load_z bit=%0d got=%b exp=%b", i, z, e); end
        end
        checks++;
        if (match_count !== 8'd2) begin failures++; $display("FAIL load_cnt got=%0d exp=2", match_count); end
    endtask

    task automatic test_saturation();
        int exp_c;
        do_reset(1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b1);
            exp_c = (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2);
            checks++;
            if (z2 !== (i >= 3)) begin failures++; $display("FAIL sat_z bit=%0d got=%b exp=%b", i, z2, (i >= 3)); end
            checks++;
            if (match_count2 !== 2'(exp_c) || mcnt2 != exp_c) begin
                failures++; $display("FAIL sat_cnt bit=%0d got=%0d exp=%0d", i, match_count2, exp_c);
            end
        end
        checks++;
        if (match_count !== 8'd4) begin failures++; $display("FAIL sat_wide_cnt got=%0d exp=4", match_count); end
    endtask

    task automatic test_gaps();
        bit p[4] = '{1,0,1,0};
        int pulses = 0;
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            drive(p[i], 1'b1, 1'b0);
            checks++;
            if (z !== (i == 3) || z !== mz) begin failures++; $display("FAIL gap_z bit=%0d got=%b exp=%b", i, z, (i == 3)); end
            if (z) pulses++;
            for (int g = 0; g < 3; g++) begin
                drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
                if (z) pulses++;
            end
        end
        checks++;
        if (pulses != 1 || match_count !== 8'd1) begin
            failures++; $display("FAIL gap_pulses got=%0d cnt=%0d exp=1 cnt=1", pulses, match_count);
        end
    endtask

    task automatic test_reset_mid();
        bit a[3] = '{1,0,1};
        bit b[3] = '{0,1,0};
        int pulses = 0;
        do_reset(1);
        for (int i = 0; i < 3; i++) drive(a[i], 1'b1, 1'b0);
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            drive(b[i], 1'b1, 1'b0);
            if (z) pulses++;
        end
        checks++;
        if (pulses != 0 || match_count !== 8'd0) begin
            failures++; $display("FAIL rstmid got pulses=%0d cnt=%0d exp 0/0", pulses, match_count);
        end
    endtask

    task automatic test_random();
        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0)
                drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 4'($urandom_range(0, 15)));
            else
                drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            checks++;
            if (z !== mz || match_count !== 8'(mcnt) || match_count2 !== 2'(mcnt2)) begin
                failures++;
                $display("FAIL rand cyc=%0d z=%b/%b cnt=%0d/%0d sat=%0d/%0d (got/exp)",
                         i, z, mz, match_count, mcnt, match_count2, mcnt2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nonoverlap();
        test_overlap();
        test_load();
        test_saturation();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
